// File: rtl/pc_fetch_unit.sv
// Instruction fetch/sequencer for a 2K x 14 program ROM, with a circular return stack.
// Optional macro STACK_OVF_FLAG_EN adds an occupancy counter and sticky stk_ovf/stk_unf flags.
module pc_fetch_unit #(
  parameter logic [10:0] RESET_VECTOR = 11'h000,
  parameter int          STACK_DEPTH  = 8,
  parameter logic [13:0] NOP_WORD     = 14'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        skip,
  input  logic [13:0] rom_data_in,
  output logic [10:0] rom_addr_out,
  output logic [13:0] ir_out,
  output logic        ir_valid,
  output logic [10:0] ir_pc,
  output logic        stk_ovf,
  output logic        stk_unf
);

  localparam int SP_W = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {BR_NONE, BR_GOTO, BR_CALL, BR_RET} br_e;

  logic [10:0]     pc;
  logic [10:0]     pc_nxt;
  logic [10:0]     pc_inc;
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_dec;
  logic [10:0]     stack [STACK_DEPTH];
  br_e             br;
  logic            bubble;
  logic            push;
  logic            pop;

  assign rom_addr_out = pc;
  assign pc_inc       = pc + 11'd1;
  assign sp_dec       = sp - SP_W'(1);
  assign push         = !stall && (br == BR_CALL);
  assign pop          = !stall && (br == BR_RET);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    br = BR_NONE;
    if (ir_valid) begin
      if (ir_out[13:11] == 3'b101)      br = BR_GOTO;
      else if (ir_out[13:11] == 3'b100) br = BR_CALL;
      else if (ir_out == 14'h0008 || ir_out[13:10] == 4'b1101) br = BR_RET;
    end
  end

  // A branch in IR always bubbles the word being fetched; skip only matters otherwise.
  always_comb begin
    pc_nxt = pc_inc;
    bubble = skip;
    case (br)
      BR_GOTO, BR_CALL: begin
        pc_nxt = ir_out[10:0];
        bubble = 1'b1;
      end
      BR_RET: begin
        pc_nxt = stack[sp_dec];
        bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      ir_out   <= NOP_WORD;
      ir_valid <= 1'b0;
      ir_pc    <= '0;
      sp       <= '0;
    end else if (!stall) begin
      pc    <= pc_nxt;
      ir_pc <= pc;
      if (bubble) begin
        ir_out   <= NOP_WORD;
        ir_valid <= 1'b0;
      end else begin
        ir_out   <= rom_data_in;
        ir_valid <= 1'b1;
      end
      if (push)     sp <= sp + SP_W'(1);
      else if (pop) sp <= sp_dec;
    end
  end

  // NOTE: the stack array has no reset; only sp is cleared, which keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && push) stack[sp] <= pc;
  end

`ifdef STACK_OVF_FLAG_EN
  localparam logic [SP_W:0] DEPTH_FULL = (SP_W+1)'(STACK_DEPTH);

  logic [SP_W:0] depth;

  // Occupancy saturates at full/empty; the pointer itself keeps wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth   <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      if (push) begin
        if (depth == DEPTH_FULL) stk_ovf <= 1'b1;
        else                     depth   <= depth + (SP_W+1)'(1);
      end
      if (pop) begin
        if (depth == '0) stk_unf <= 1'b1;
        else             depth   <= depth - (SP_W+1)'(1);
      end
    end
  end
`else
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected (word, address) pairs are queued up front and
// a negedge monitor compares every instruction the execute stage consumes.
module tb_pc_fetch_unit;

`ifdef STACK_OVF_FLAG_EN
  localparam logic FLAG_EN = 1'b1;
`else
  localparam logic FLAG_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic        skip;
  logic [13:0] rom_data_in;
  logic [10:0] rom_addr_out;
  logic [13:0] ir_out;
  logic        ir_valid;
  logic [10:0] ir_pc;
  logic        stk_ovf;
  logic        stk_unf;

  logic [13:0] rom [2048];
  logic [24:0] exp_q [$];
  logic        mon_en;
  int          checks;
  int          errors;

  pc_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .skip         (skip),
    .rom_data_in  (rom_data_in),
    .rom_addr_out (rom_addr_out),
    .ir_out       (ir_out),
    .ir_valid     (ir_valid),
    .ir_pc        (ir_pc),
    .stk_ovf      (stk_ovf),
    .stk_unf      (stk_unf)
  );

  assign rom_data_in = rom[rom_addr_out];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_ir(input logic [13:0] word, input logic [10:0] addr);
    exp_q.push_back({word, addr});
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 2048; a++) rom[a] = 14'h3FFF;
  endtask

  // An instruction is consumed on an edge where it is valid and execute is not stalled.
  always @(negedge clk) begin
    if (mon_en && ir_valid && !stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%h@%h required=none", ir_out, ir_pc);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        if ({ir_out, ir_pc} !== e) begin
          errors++;
          $display("FAIL sb_ir actual=%h@%h required=%h@%h", ir_out, ir_pc, e[24:11], e[10:0]);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    reset  = 1'b1;
    stall  = 1'b0;
    skip   = 1'b0;

    // Straight-line code, CALL/RETURN, GOTO loop-back, skip, and stall on a CALL.
    clear_rom();
    rom[11'h000] = 14'h300F; rom[11'h001] = 14'h00A4; rom[11'h002] = 14'h01A5;
    rom[11'h003] = 14'h3001; rom[11'h004] = 14'h3004; rom[11'h005] = 14'h3005;
    rom[11'h006] = 14'h3006; rom[11'h007] = 14'h2014; rom[11'h008] = 14'h0BA4;
    rom[11'h009] = 14'h2803; rom[11'h00A] = 14'h0BA4; rom[11'h00B] = 14'h3077;
    rom[11'h00C] = 14'h3088; rom[11'h014] = 14'h301E; rom[11'h015] = 14'h0008;

    expect_ir(14'h300F, 11'h000); expect_ir(14'h00A4, 11'h001); expect_ir(14'h01A5, 11'h002);
    expect_ir(14'h3001, 11'h003); expect_ir(14'h3004, 11'h004); expect_ir(14'h3005, 11'h005);
    expect_ir(14'h3006, 11'h006); expect_ir(14'h2014, 11'h007); expect_ir(14'h301E, 11'h014);
    expect_ir(14'h0008, 11'h015); expect_ir(14'h0BA4, 11'h008); expect_ir(14'h2803, 11'h009);
    expect_ir(14'h3001, 11'h003); expect_ir(14'h3004, 11'h004); expect_ir(14'h3005, 11'h005);
    expect_ir(14'h3006, 11'h006); expect_ir(14'h2014, 11'h007); expect_ir(14'h301E, 11'h014);
    expect_ir(14'h0008, 11'h015); expect_ir(14'h0BA4, 11'h008); expect_ir(14'h0BA4, 11'h00A);
    expect_ir(14'h3077, 11'h00B); expect_ir(14'h3088, 11'h00C);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_addr",     32'(rom_addr_out), 32'h000);
    check("rst_ir_valid", 32'(ir_valid),     32'h0);
    check("rst_ir_out",   32'(ir_out),       32'h0000);
    check("rst_ir_pc",    32'(ir_pc),        32'h000);
    check("rst_flags",    32'({stk_ovf, stk_unf}), 32'h0);
    mon_en = 1'b1;

    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      case (k)
        9:  check("call_target", 32'(rom_addr_out), 32'h014);
        12: check("ret_target",  32'(rom_addr_out), 32'h008);
        14: skip = 1'b1;
        15: begin
          skip = 1'b0;
          check("goto_over_skip", 32'(rom_addr_out), 32'h003);
        end
        20: stall = 1'b1;
        21, 22: begin
          check("stall_addr", 32'(rom_addr_out), 32'h008);
          check("stall_ir",   32'(ir_out),       32'h2014);
        end
        23: begin
          check("stall_addr", 32'(rom_addr_out), 32'h008);
          check("stall_ir",   32'(ir_out),       32'h2014);
          stall = 1'b0;
        end
        28: skip = 1'b1;
        29: begin
          skip = 1'b0;
          check("skip_bubble", 32'(ir_valid),     32'h0);
          check("skip_addr",   32'(rom_addr_out), 32'h00A);
        end
        default: ;
      endcase
    end
    @(negedge clk);
    #1;
    check("drain_a", 32'(exp_q.size()), 32'h0);
    check("flags_a", 32'({stk_ovf, stk_unf}), 32'h0);
    mon_en = 1'b0;

    // Reset outranks a simultaneous stall.
    stall = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_stall_addr",  32'(rom_addr_out), 32'h000);
    check("rst_stall_valid", 32'(ir_valid),     32'h0);
    check("rst_stall_pc",    32'(ir_pc),        32'h000);
    stall = 1'b0;

    // Nine nested CALLs through a depth-8 stack, then nine RETURNs.
    clear_rom();
    for (int i = 0; i < 9; i++) begin
      rom[11'(16 * i)]     = 14'h2000 | 14'(16 * (i + 1));
      rom[11'(16 * i + 1)] = 14'h0008;
      expect_ir(14'h2000 | 14'(16 * (i + 1)), 11'(16 * i));
    end
    rom[11'h090] = 14'h0008;
    expect_ir(14'h0008, 11'h090);
    for (int j = 0; j < 8; j++) expect_ir(14'h0008, 11'(8'h81 - 8'(16 * j)));

    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    for (int k = 1; k <= 36; k++) begin
      @(posedge clk);
      #1;
      case (k)
        16: check("ovf_at_8_calls", 32'(stk_ovf), 32'h0);
        18: begin
          check("ovf_at_9_calls", 32'(stk_ovf),      32'(FLAG_EN));
          check("ninth_call_tgt", 32'(rom_addr_out), 32'h090);
        end
        34: begin
          check("ret8_target",  32'(rom_addr_out), 32'h011);
          check("unf_at_8_ret", 32'(stk_unf),      32'h0);
        end
        36: begin
          check("ret9_target",  32'(rom_addr_out), 32'h081);
          check("unf_at_9_ret", 32'(stk_unf),      32'(FLAG_EN));
          check("ovf_sticky",   32'(stk_ovf),      32'(FLAG_EN));
        end
        default: ;
      endcase
    end
    @(negedge clk);
    #1;
    check("drain_b", 32'(exp_q.size()), 32'h0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
